// File: rtl/sigdelay_pkg.sv
// rtl/sigdelay_pkg.sv - shared types and sample arithmetic for the echo delay line
// Samples travel offset-binary; arithmetic helpers work on signed ints.
package sigdelay_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_DELAY  = 2'b01,
      MODE_ECHO   = 2'b10,
      MODE_MIX    = 2'b11
   } mode_t;

   function automatic int mid_val(input int w);
      return 1 << (w - 1);
   endfunction

   // Subtracting midscale is the same as inverting the MSB.
   function automatic int ob_to_s(input int x, input int w);
      return x - mid_val(w);
   endfunction

   function automatic int s_to_ob(input int x, input int w);
      return x + mid_val(w);
   endfunction

   function automatic int sat_add(input int a, input int b, input int w);
      int s;
      s = a + b;
      if (s > mid_val(w) - 1) return mid_val(w) - 1;
      if (s < -mid_val(w)) return -mid_val(w);
      return s;
   endfunction

endpackage

// File: rtl/ram2ports.sv
// rtl/ram2ports.sv - simple dual-port RAM, one write port and one registered read port
// Read-during-write to the same address is left undefined for callers.
module ram2ports #(
   parameter int A_WIDTH = 8,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [A_WIDTH-1:0] wr_addr,
   input  logic [D_WIDTH-1:0] wr_data,
   input  logic               rd_en,
   input  logic [A_WIDTH-1:0] rd_addr,
   output logic [D_WIDTH-1:0] rd_data
);

   logic [D_WIDTH-1:0] r_mem [0:(1<<A_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= r_mem[rd_addr];
   end

endmodule

// File: rtl/sigdelay_echo.sv
// rtl/sigdelay_echo.sv - programmable circular-buffer delay with bypass/delay/echo/mix modes
// Two-stage pipeline: stage 1 reads the tap, stage 2 combines, writes back and registers dout.
module sigdelay_echo
   import sigdelay_pkg::*;
#(
   parameter int A_WIDTH = 8,
   parameter int D_WIDTH = 8,
   parameter int S_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [A_WIDTH-1:0] delay,
   input  logic [S_WIDTH-1:0] fb_shift,
   input  logic [D_WIDTH-1:0] din,
   output logic [D_WIDTH-1:0] dout,
   output logic               dout_valid,
   output logic               filled
);

   localparam logic [D_WIDTH-1:0] MID = D_WIDTH'(mid_val(D_WIDTH));

   logic [A_WIDTH-1:0] r_wr_ptr, r_fill, r_delay, r_s2_addr;
   logic               r_s2_valid, r_s2_mask, r_s2_fwd, r_dout_valid;
   logic [D_WIDTH-1:0] r_s2_din, r_fwd_data, r_dout;
   mode_t              r_s2_mode;
   logic [S_WIDTH-1:0] r_s2_shift;

   logic [A_WIDTH-1:0] w_rd_addr, w_fill_eff;
   logic               w_delay_chg, w_mask, w_fwd;
   logic [D_WIDTH-1:0] w_ram_q, w_tap, w_sum, w_wval, w_out;
   int                 w_din_s, w_tap_s;

   assign w_rd_addr   = r_wr_ptr - delay;
   assign w_delay_chg = (delay != r_delay);
   assign w_fill_eff  = w_delay_chg ? '0 : r_fill;
   assign w_mask      = (delay == '0) || (w_fill_eff < delay);
   // The sample in stage 2 has not reached the RAM yet when the next read targets it.
   assign w_fwd       = r_s2_valid && (w_rd_addr == r_s2_addr);

   ram2ports #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
      .clk     (clk),
      .wr_en   (r_s2_valid && !rst),
      .wr_addr (r_s2_addr),
      .wr_data (w_wval),
      .rd_en   (en),
      .rd_addr (w_rd_addr),
      .rd_data (w_ram_q)
   );

   always_comb begin
      w_tap = MID;
      if (!r_s2_mask) w_tap = r_s2_fwd ? r_fwd_data : w_ram_q;
      w_din_s = ob_to_s(int'(r_s2_din), D_WIDTH);
      w_tap_s = ob_to_s(int'(w_tap), D_WIDTH) >>> r_s2_shift;
      w_sum   = D_WIDTH'(s_to_ob(sat_add(w_din_s, w_tap_s, D_WIDTH), D_WIDTH));
      w_wval  = r_s2_din;
      w_out   = r_s2_din;
      case (r_s2_mode)
         MODE_BYPASS: w_out = r_s2_din;
         MODE_DELAY:  w_out = w_tap;
         MODE_ECHO:   begin w_wval = w_sum; w_out = w_sum; end
         MODE_MIX:    w_out = w_sum;
         default:     w_out = r_s2_din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_fill       <= '0;
         r_delay      <= '0;
         r_s2_valid   <= 1'b0;
         r_dout       <= MID;
         r_dout_valid <= 1'b0;
      end else begin
         r_s2_valid   <= en;
         r_dout_valid <= r_s2_valid;
         if (r_s2_valid) r_dout <= w_out;
         if (en) begin
            r_s2_din   <= din;
            r_s2_mode  <= mode_t'(mode);
            r_s2_shift <= fb_shift;
            r_s2_addr  <= r_wr_ptr;
            r_s2_mask  <= w_mask;
            r_s2_fwd   <= w_fwd;
            r_fwd_data <= w_wval;
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_delay    <= delay;
            if (w_delay_chg) r_fill <= (delay != '0) ? {{(A_WIDTH-1){1'b0}}, 1'b1} : '0;
            else if (r_fill < delay) r_fill <= r_fill + 1'b1;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign filled     = (r_fill == r_delay) && (r_delay != '0);

endmodule

// File: tb/tb_sigdelay_echo.sv
// tb/tb_sigdelay_echo.sv - self-checking bench for sigdelay_echo against a sample-history model
// Directed scenarios followed by randomized traffic, all checked with immediate assertions.
module tb_sigdelay_echo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] delay = 4'd0;
   logic [2:0] fb_shift = 3'd0;
   logic [7:0] din = 8'd0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       filled;

   int n_cmp = 0;
   int n_bad = 0;

   int hist[$];
   int outs[$];
   int m_since = 0, m_stored = 0;
   bit p_en = 0;
   int p_exp = 128, last_out = 128;

   sigdelay_echo #(.A_WIDTH(4), .D_WIDTH(8), .S_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .delay(delay), .fb_shift(fb_shift),
      .din(din), .dout(dout), .dout_valid(dout_valid), .filled(filled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clamp8(input int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   task automatic step(input bit e, input int d, input int m, input int dl, input int sh);
      int tap, sum, w, o;
      bit masked;
      en = e; din = d[7:0]; mode = m[1:0]; delay = dl[3:0]; fb_shift = sh[2:0];
      @(posedge clk); #1;
      chk("dout_valid", int'(dout_valid), int'(p_en));
      if (p_en) last_out = p_exp;
      chk("dout", int'(dout), last_out);
      if (dout_valid) outs.push_back(int'(dout));
      if (e) begin
         if (dl != m_stored) begin m_since = 0; m_stored = dl; end
         masked = (dl == 0) || (m_since < dl);
         tap = masked ? 128 : hist[hist.size() - dl];
         sum = clamp8((d - 128) + ((tap - 128) >>> sh)) + 128;
         case (m)
            0: begin w = d; o = d; end
            1: begin w = d; o = tap; end
            2: begin w = sum; o = sum; end
            default: begin w = d; o = sum; end
         endcase
         hist.push_back(w);
         if (m_since < dl) m_since++;
         p_exp = o;
      end
      p_en = e;
      chk("filled", int'(filled), int'((m_since == m_stored) && (m_stored != 0)));
      en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_dout", int'(dout), 128);
      chk("rst_filled", int'(filled), 0);
      rst = 1'b0;
      hist.delete(); m_since = 0; m_stored = 0; p_en = 0; last_out = 128;
   endtask

   initial begin
      int vals[5];
      int dl, m, sh;
      vals = '{10, 20, 30, 40, 50};

      do_reset();

      outs.delete();
      for (int i = 0; i < 5; i++) step(1, vals[i], 1, 3, 0);
      step(0, 0, 1, 3, 0);
      step(0, 0, 1, 3, 0);
      chk("s1_cnt", outs.size(), 5);
      if (outs.size() == 5) begin
         chk("s1_o0", outs[0], 128); chk("s1_o2", outs[2], 128);
         chk("s1_o3", outs[3], 10);  chk("s1_o4", outs[4], 20);
      end

      for (int i = 0; i < 256; i++) begin
         step(1, i, 0, 3, 0);
         step(0, 0, 0, 3, 0);
      end

      outs.delete();
      step(1, 192, 2, 1, 1);
      for (int i = 0; i < 6; i++) step(1, 128, 2, 1, 1);
      for (int i = 0; i < 8; i++) step(1, 255, 2, 1, 1);
      step(0, 0, 2, 1, 1);
      step(0, 0, 2, 1, 1);
      chk("echo_cnt", outs.size(), 15);
      if (outs.size() == 15) begin
         chk("echo_o0", outs[0], 192); chk("echo_o1", outs[1], 160);
         chk("echo_o2", outs[2], 144); chk("echo_o3", outs[3], 136);
         chk("echo_sat", outs[14], 255);
      end

      outs.delete();
      for (int i = 0; i < 8; i++) step(1, 200, 3, 4, 0);
      step(0, 0, 3, 4, 0);
      step(0, 0, 3, 4, 0);
      if (outs.size() == 8) begin
         chk("mix_o3", outs[3], 200); chk("mix_o4", outs[4], 255); chk("mix_o7", outs[7], 255);
      end else chk("mix_cnt", outs.size(), 8);

      for (int i = 0; i < 40; i++) step(1, $urandom_range(0, 255), 1, 15, 0);
      for (int i = 0; i < 20; i++) step(1, $urandom_range(0, 255), 1, 5, 0);

      step(1, 77, 1, 3, 0);
      do_reset();
      outs.delete();
      for (int i = 0; i < 3; i++) step(1, 90 + i, 1, 3, 0);
      step(0, 0, 1, 3, 0);
      step(0, 0, 1, 3, 0);
      chk("rst_cnt", outs.size(), 3);
      foreach (outs[i]) chk("rst_mask", outs[i], 128);

      dl = 6; m = 2; sh = 2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) dl = $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) m = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) sh = $urandom_range(0, 7);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 255), m, dl, sh);
      end
      step(0, 0, m, dl, sh);
      step(0, 0, m, dl, sh);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sigdelay_echo.md
Name: sigdelay_echo

Overview:
- Parametrised successor to the fixed-depth signal delay block: a circular-buffer delay line with a run-time programmable delay and four modes (bypass, pure delay, feedback echo, feed-forward mix).
- Sits between the mic/ADC sample source and the DAC/plot path; `en` is the sample strobe.
- Built on the existing ram2ports dual-port RAM, with separate read and write pointers.
- Masks stale RAM contents until the programmed delay has been filled.

Parameters:
- A_WIDTH, 8: buffer address width; depth = 2^A_WIDTH samples; programmable delay range 0..2^A_WIDTH-1.
- D_WIDTH, 8: sample width; samples are offset-binary, with midscale MID = 2^(D_WIDTH-1).
- S_WIDTH, 3: width of the feedback shift control.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: sample strobe; one sample accepted per cycle with en=1.
- mode, input, 2: 00 bypass, 01 delay, 10 echo, 11 mix; sampled on en.
- delay, input, A_WIDTH: delay in samples; sampled on en.
- fb_shift, input, S_WIDTH: attenuation of the tap, tap>>>fb_shift (signed); sampled on en.
- din, input, D_WIDTH: input sample, offset-binary.
- dout, output, D_WIDTH: processed sample, offset-binary.
- dout_valid, output, 1: one-cycle pulse marking a new dout.
- filled, output, 1: high once `delay` samples have been written since the last reset or delay change.

Behaviour:
- Reset values: wr_ptr=0, fill=0, stored delay=0, dout=MID, dout_valid=0, filled=0. Stage-2 pipeline valid is cleared, so any in-flight write is discarded. RAM contents are not cleared.
- Internal arithmetic is signed: invert the MSB on entry and again on exit. Sums use D_WIDTH+1 bits and saturate to the signed D_WIDTH range, i.e. offset-binary 0..2^D_WIDTH-1.
- Stage 1, cycle n with en=1:
  - Issue RAM read at rd_addr = wr_ptr - delay (mod 2^A_WIDTH).
  - Capture din, mode, fb_shift and wr_addr = wr_ptr.
  - Increment wr_ptr with wrap at 2^A_WIDTH-1 -> 0.
- Stage 2, cycle n+1:
  - Tap is defined as follows:
    - tap = MID if delay==0 or fill<delay;
    - otherwise tap = the forwarded value when a forward applies (see below);
    - otherwise tap = RAM data.
  - Compute by mode:
    - 00 bypass: wval=din, out=din.
    - 01 delay: wval=din, out=tap.
    - 10 echo: wval=sat(din + (tap>>>fb_shift)), out=wval.
    - 11 mix: wval=din, out=sat(din + (tap>>>fb_shift)).
  - Write wval to ram[wr_addr].
- Output timing: dout and dout_valid register at the end of cycle n+1, so they are visible in cycle n+2. Latency is 2 cycles in all modes. dout holds its value between pulses.
- Back-to-back en:
  - With delay==1, the stage-1 read address equals the stage-2 write address in the same cycle.
  - Required: forward the stage-2 wval into the next sample's tap. No read-during-write dependence on RAM behaviour.
- Fill counter:
  - Increments per en, saturating at delay.
  - A delay value on en different from the stored delay resets fill to 0 (that sample counts as the first) and updates the stored delay.
  - filled = (fill == stored delay) && (stored delay != 0).
- Mode and fb_shift changes take effect on the next sample without flushing. Only a delay change restarts fill.
- en=0: no pointer, fill or RAM update; stage 2 still completes any pending sample.
- Reset mid-operation: takes priority over en; the pending sample produces no dout_valid.

Decomposition:
- Package sigdelay_pkg holds:
  - mode_t enum: MODE_BYPASS, MODE_DELAY, MODE_ECHO, MODE_MIX;
  - saturating add function;
  - offset-binary <-> signed conversion functions;
  - MID constant function of D_WIDTH.
- Sub-module: reuse ram2ports, with wr_addr/rd_addr driven separately, rd_en=en, wr_en=stage-2 valid.
- Pointer and fill logic stay inline; no separate counter instance is needed.

Test Plan:
- Bench configuration for all scenarios: A_WIDTH=4, D_WIDTH=8.
- Reset, then en every cycle, mode=01, delay=3, din=10,20,30,40,50:
  - dout = 128,128,128,10,20, each 2 cycles after its en;
  - filled rises with the 3rd sample.
- Mode=00, din ramp 0..255 with en every other cycle: dout equals din at 2-cycle latency; dout_valid pulses once per en.
- Mode=10, delay=1, fb_shift=1, din=MID+64 (192) then MID repeatedly:
  - dout = 192, 160, 144, 136, ... (forwarding path exercised);
  - then din=255 back-to-back saturates dout at 255.
- Mode=11, delay=4, fb_shift=0, din=200 constant: dout = 200 x4, then 255 (saturated); the RAM keeps plain din.
- Wrap-around: delay=15 with 40 samples -> dout[k]=din[k-15]. Then change delay to 5 mid-stream: filled drops, dout=128 for 5 samples, then din[k-5].
- Assert rst in the cycle after an en: no dout_valid follows; dout=128, filled=0; the next 3 samples with delay=3 output 128.
